// File: rtl/regfile_mp_sb.sv
// Multi-port RV32 integer register file: two write ports (A = EX, B = MEM),
// write-through bypass on every read port, and a per-register pending scoreboard.
module regfile_mp_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]       rd_data,
  output logic [NRD-1:0]            rd_busy,
  input  logic                      wa_en,
  input  logic [$clog2(NREGS)-1:0]  wa_addr,
  input  logic [XLEN-1:0]           wa_data,
  input  logic                      wb_en,
  input  logic [$clog2(NREGS)-1:0]  wb_addr,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      iss_en,
  input  logic [$clog2(NREGS)-1:0]  iss_addr,
  input  logic                      flush,
  output logic                      any_pending
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic             any_pending_q;
  logic [NREGS-1:0] wa_hit;
  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] iss_hit;

  // Address decode per port; register 0 is masked out when hardwired to zero.
  always_comb begin
    wa_hit  = '0;
    wb_hit  = '0;
    iss_hit = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      wa_hit[i]  = wa_en  && (wa_addr  == AW'(i));
      wb_hit[i]  = wb_en  && (wb_addr  == AW'(i));
      iss_hit[i] = iss_en && (iss_addr == AW'(i));
    end
    if (ZERO_REG) begin
      wa_hit[0]  = 1'b0;
      wb_hit[0]  = 1'b0;
      iss_hit[0] = 1'b0;
    end
    // Flush first, then writes clear, then a new issue re-marks (set wins).
    pending_d = ((flush ? '0 : pending_q) & ~(wa_hit | wb_hit)) | iss_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      pending_q     <= '0;
      any_pending_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (wb_hit[i]) begin
          regs_q[i] <= wb_data;
        end else if (wa_hit[i]) begin
          regs_q[i] <= wa_data;
        end
      end
      pending_q     <= pending_d;
      any_pending_q <= |pending_d;
    end
  end

  assign any_pending = any_pending_q;

  // Read ports: B bypass beats A bypass beats stored value; x0 reads zero.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] data;
    logic            a_byp;
    logic            b_byp;
    logic            zero;

    assign a     = rd_addr[k*AW +: AW];
    assign a_byp = wa_en && (wa_addr == a);
    assign b_byp = wb_en && (wb_addr == a);
    assign zero  = ZERO_REG && (a == '0);

    always_comb begin
      data = regs_q[a];
      if (a_byp) data = wa_data;
      if (b_byp) data = wb_data;
      if (zero)  data = '0;
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k] = pending_q[a] && !a_byp && !b_byp && !zero;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: reset, write/read, bypass priority,
// scoreboard set/clear/flush and asynchronous reset mid-stream.
module tb_regfile_mp_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic                clk;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wa_en;
  logic [AW-1:0]       wa_addr;
  logic [XLEN-1:0]     wa_data;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic                any_pending;

  int n_assert;
  int n_fail;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .any_pending(any_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  // Advance one rising edge, then settle so inputs change away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    rd_addr = '0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    #12;
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state across all addresses on both ports.
    for (int a = 0; a < int'(NREGS); a++) begin
      rd(AW'(a), AW'(NREGS - 1 - a));
      chk($sformatf("reset_p0_data_x%0d", a), rd_data[0 +: XLEN], '0);
      chk($sformatf("reset_p1_data_x%0d", NREGS - 1 - a), rd_data[XLEN +: XLEN], '0);
      chk($sformatf("reset_busy_x%0d", a), XLEN'(rd_busy), '0);
    end
    chk("reset_any_pending", XLEN'(any_pending), '0);

    // Write then read.
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h1234_5678;
    tick();
    idle();
    rd(5'd5, 5'd0);
    chk("wr_x5_read", rd_data[0 +: XLEN], 32'h1234_5678);

    // Write to x0 is ignored, including the bypass path.
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
    rd(5'd0, 5'd0);
    chk("wr_x0_bypass", rd_data[0 +: XLEN], '0);
    tick();
    idle();
    rd(5'd0, 5'd5);
    chk("wr_x0_read", rd_data[0 +: XLEN], '0);
    chk("x5_unchanged", rd_data[XLEN +: XLEN], 32'h1234_5678);

    // Port A bypass alone.
    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'h0000_CAFE;
    rd(5'd5, 5'd10);
    chk("bypass_a_x10", rd_data[XLEN +: XLEN], 32'h0000_CAFE);
    tick();
    idle();

    // Both ports write x7 in one cycle: B wins in bypass and in storage.
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'hAAAA_0000;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h5555_1111;
    rd(5'd10, 5'd7);
    chk("bypass_prio_p1_x7", rd_data[XLEN +: XLEN], 32'h5555_1111);
    chk("x10_stored", rd_data[0 +: XLEN], 32'h0000_CAFE);
    tick();
    idle();
    rd(5'd7, 5'd7);
    chk("stored_prio_x7", rd_data[0 +: XLEN], 32'h5555_1111);

    // Scoreboard: issue x9, becomes pending after the edge.
    iss_en = 1'b1; iss_addr = 5'd9;
    rd(5'd9, 5'd5);
    chk("iss_x9_busy_same_cycle", XLEN'(rd_busy), '0);
    tick();
    idle();
    rd(5'd9, 5'd5);
    chk("iss_x9_busy", XLEN'(rd_busy), 32'd1);
    chk("iss_x9_any_pending", XLEN'(any_pending), 32'd1);

    // Load writeback supplies x9: not busy, bypassed data, cleared after the edge.
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0042;
    rd(5'd5, 5'd9);
    chk("wb_x9_busy", XLEN'(rd_busy), '0);
    chk("wb_x9_data", rd_data[XLEN +: XLEN], 32'h0000_0042);
    tick();
    idle();
    rd(5'd9, 5'd9);
    chk("x9_cleared_busy", XLEN'(rd_busy), '0);
    chk("x9_cleared_any", XLEN'(any_pending), '0);
    chk("x9_data", rd_data[0 +: XLEN], 32'h0000_0042);

    // Set and clear of x3 together: set wins.
    iss_en = 1'b1; iss_addr = 5'd3;
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h0000_0033;
    tick();
    idle();
    rd(5'd3, 5'd4);
    chk("collide_x3_busy", XLEN'(rd_busy), 32'd1);
    chk("collide_x3_data", rd_data[0 +: XLEN], 32'h0000_0033);
    chk("collide_any", XLEN'(any_pending), 32'd1);

    // Mark x6 as well, then flush with issue x4: only x4 remains.
    iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    idle();
    rd(5'd3, 5'd6);
    chk("pre_flush_busy", XLEN'(rd_busy), 32'd3);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
    tick();
    idle();
    rd(5'd3, 5'd6);
    chk("flush_x3_x6_busy", XLEN'(rd_busy), '0);
    rd(5'd4, 5'd3);
    chk("flush_x4_busy", XLEN'(rd_busy), 32'd1);
    chk("flush_any", XLEN'(any_pending), 32'd1);
    chk("flush_keeps_x3", rd_data[XLEN +: XLEN], 32'h0000_0033);

    // Clear x4 while issuing to x0: x0 never marks, nothing pending.
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0044;
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle();
    rd(5'd0, 5'd4);
    chk("iss_x0_busy", XLEN'(rd_busy), '0);
    chk("iss_x0_any", XLEN'(any_pending), '0);
    chk("x4_data", rd_data[XLEN +: XLEN], 32'h0000_0044);

    // Asynchronous reset between edges with x9 pending and x5 nonzero.
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    rd(5'd9, 5'd5);
    chk("pre_rst_busy", XLEN'(rd_busy), 32'd1);
    chk("pre_rst_x5", rd_data[XLEN +: XLEN], 32'h1234_5678);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_x5", rd_data[XLEN +: XLEN], '0);
    chk("async_rst_busy", XLEN'(rd_busy), '0);
    chk("async_rst_any", XLEN'(any_pending), '0);
    @(negedge clk);
    reset = 1'b0;
    rd(5'd7, 5'd4);
    chk("post_rst_x7", rd_data[0 +: XLEN], '0);
    chk("post_rst_x4", rd_data[XLEN +: XLEN], '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined RV32 core.
- Replaces the single-write, two-read file with:
  - NRD combinational read ports;
  - two write ports: A = ALU/EX writeback, B = load/MEM writeback;
  - write-through bypass on every read port;
  - a per-register pending scoreboard used by decode for hazard stalls.
- Sits between decode (reads, issue marking) and writeback (two write streams).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NRD, 2, number of read ports.
- ZERO_REG, 1: 1 hardwires register 0 to zero and never marks it pending; 0 makes register 0 an ordinary register.
- AW (localparam), clog2(NREGS), register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registers and pending bits.
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data, combinational.
- rd_busy  out  NRD  per-port flag: the addressed register is pending and no write in this cycle supplies it.
- wa_en  in  1  write port A enable.
- wa_addr  in  AW  write port A address.
- wa_data  in  XLEN  write port A data.
- wb_en  in  1  write port B enable.
- wb_addr  in  AW  write port B address.
- wb_data  in  XLEN  write port B data.
- iss_en  in  1  decode issued an instruction that will write iss_addr.
- iss_addr  in  AW  destination of the issued instruction.
- flush  in  1  synchronous clear of all pending bits (branch flush); register contents are unaffected.
- any_pending  out  1  registered OR of all pending bits.

Behaviour:
- Reset (asynchronous):
  - all NREGS registers = 0;
  - pending[] = 0, any_pending = 0;
  - rd_data therefore reads 0, rd_busy = 0.
- Write, rising edge:
  - reg[wa_addr] <= wa_data if wa_en; reg[wb_addr] <= wb_data if wb_en.
  - If wa_en && wb_en && wa_addr == wb_addr, port B wins and port A's data is discarded.
  - With ZERO_REG=1, any write to address 0 is ignored.
- Read (combinational, zero latency), per port k with address a:
  - ZERO_REG && a==0 -> 0;
  - else wb_en && wb_addr==a -> wb_data;
  - else wa_en && wa_addr==a -> wa_data;
  - else reg[a].
- Scoreboard:
  - Clear: pending[x] clears on any write (A or B) to x.
  - Set: pending[x] sets when iss_en && iss_addr==x.
  - Set and clear of the same x in one cycle: set wins; the new producer owns x.
  - flush: clears all pending bits, then iss_en is applied in the same cycle, so pending = {iss_addr} only.
  - With ZERO_REG=1, iss_addr==0 never sets a bit.
- rd_busy[k]:
  - = pending[a] && !(wa_en && wa_addr==a) && !(wb_en && wb_addr==a);
  - always 0 for a==0 when ZERO_REG=1.
- any_pending is registered; it reflects pending[] after the edge, one cycle after the causing event.
- Width rules:
  - addresses are exactly AW bits, no out-of-range addresses exist;
  - data is not sign- or zero-extended inside the block.
- Reset asserted mid-operation:
  - in-flight writes and issue marks in that cycle are lost;
  - outputs go to reset values immediately; no glitch recovery is required.

Test Plan:
- Reset check:
  - Stimulus: reset pulse, then read addresses 0..31 on both ports.
  - Required: all rd_data = 0, rd_busy = 0, any_pending = 0.
- Write then read:
  - Stimulus: wa write x5=0x1234_5678; the next cycle read x5 on port 0.
  - Required: 0x1234_5678.
  - Stimulus: write x0=0xFFFF_FFFF.
  - Required: reading x0 returns 0.
- Bypass and priority:
  - Stimulus: same cycle, wa_en x7=0xAAAA_0000, wb_en x7=0x5555_1111, port 1 reads x7.
  - Required: rd_data = 0x5555_1111 in that cycle.
  - Required: after the edge, reg x7 = 0x5555_1111.
- Scoreboard:
  - Stimulus: iss_en x9.
  - Required: next cycle rd_busy for x9 = 1, any_pending = 1.
  - Stimulus: wb write x9=0x42.
  - Required: rd_busy = 0 and rd_data = 0x42 in that cycle; the following cycle pending[x9] = 0.
- Set/clear collision and flush:
  - Stimulus: iss_en x3 with wa write x3 in the same cycle.
  - Required: x3 remains pending.
  - Stimulus: flush with iss_en x4.
  - Required: only x4 pending afterwards.
- Async reset mid-stream:
  - Stimulus: assert reset between edges while x9 is pending and x5 is nonzero.
  - Required: immediate rd_data = 0 and rd_busy = 0 without waiting for a clock edge.
